// File: rtl/sample_widen.sv
// rtl/sample_widen.sv - widen WO-bit samples into the WI-bit datapath behind a 2-entry buffer
//
// Purpose:
//   Accepts WO-bit two's-complement samples, left-aligns them into WI bits
//   (x * 2^(WI-WO)) and buffers up to two samples.
//   With SYM=1 the most-negative input code is clamped to one above it.
//   Optional dither: define SAMPLE_WIDEN_DITHER_EN to fill the fraction bits
//   from a 16-bit Galois LFSR. The fraction MSB is always zero.
//
// Ports:
//   clk      in   1   clock, rising edge
//   rstn     in   1   asynchronous active-low reset
//   in_vld   in   1   input sample valid
//   in_rdy   out  1   block can accept a sample this cycle
//   in_dat   in   WO  input sample, two's complement
//   out_vld  out  1   output sample valid
//   out_rdy  in   1   downstream accepts the output sample
//   out_dat  out  WI  widened sample, two's complement
//   sat_cnt  out  16  count of clamped samples, saturating
module sample_widen #(
  parameter int WI  = 31,
  parameter int WO  = 10,
  parameter int SYM = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [WO-1:0] in_dat,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [WI-1:0] out_dat,
  output logic [15:0]   sat_cnt
);

  localparam int FW = WI - WO;

  logic          tail_vld;
  logic [WI-1:0] tail;
  logic          in_fire;
  logic          out_fire;
  logic          clamp;
  logic [WO-1:0] conv_code;
  logic [FW-1:0] frac;
  logic [WI-1:0] conv;

  // Tail is only ever filled while the head is occupied, so a full buffer
  // is exactly tail_vld; in_rdy therefore depends on registered state only.
  assign in_rdy   = !tail_vld;
  assign in_fire  = in_vld && in_rdy;
  assign out_fire = out_vld && out_rdy;

  assign clamp     = (SYM != 0) && (in_dat == {1'b1, {(WO-1){1'b0}}});
  assign conv_code = clamp ? in_dat + WO'(1) : in_dat;
  assign conv      = {conv_code, frac};

`ifdef SAMPLE_WIDEN_DITHER_EN
  logic [15:0] lfsr;

  // Galois LFSR x^16+x^14+x^13+x^11+1, stepped only on accepted samples.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lfsr <= 16'hACE1;
    end else if (in_fire) begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  // Fraction MSB held at zero so downstream round-half-away recovers the
  // original code; fractions wider than the LFSR are zero-padded above it.
  if (FW - 1 <= 16) begin : g_frac_narrow
    assign frac = {1'b0, lfsr[FW-2:0]};
  end else begin : g_frac_wide
    assign frac = {{(FW-16){1'b0}}, lfsr};
  end
`else
  assign frac = '0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_vld  <= 1'b0;
      out_dat  <= '0;
      tail_vld <= 1'b0;
      tail     <= '0;
    end else if (tail_vld) begin
      // Full: input is blocked, only the head can drain.
      if (out_fire) begin
        out_dat  <= tail;
        tail_vld <= 1'b0;
      end
    end else if (out_vld) begin
      if (out_fire && in_fire) begin
        out_dat <= conv;
      end else if (out_fire) begin
        out_vld <= 1'b0;
      end else if (in_fire) begin
        tail     <= conv;
        tail_vld <= 1'b1;
      end
    end else if (in_fire) begin
      out_dat <= conv;
      out_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sat_cnt <= '0;
    end else if (in_fire && clamp && (sat_cnt != 16'hFFFF)) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_sample_widen.sv
// tb/tb_sample_widen.sv - scoreboard bench for sample_widen (SYM=1 and SYM=0 instances)
module tb_sample_widen;

  localparam int WI = 31;
  localparam int WO = 10;

  logic          clk = 1'b0;
  logic          rstn;
  logic          in_vld;
  logic [WO-1:0] in_dat;
  logic          out_rdy;
  logic          in_rdy1, in_rdy0;
  logic          out_vld1, out_vld0;
  logic [WI-1:0] out_dat1, out_dat0;
  logic [15:0]   sat1, sat0;

  int nchk = 0;
  int nerr = 0;

  logic [WI-1:0] q1[$];
  logic [WI-1:0] q0[$];
  logic [WO-1:0] c1[$];
  logic [WO-1:0] c0[$];
  logic [15:0]   m_lfsr = 16'hACE1;

  always #5 clk = ~clk;

  sample_widen #(.WI(WI), .WO(WO), .SYM(1)) dut (
    .clk(clk), .rstn(rstn), .in_vld(in_vld), .in_rdy(in_rdy1), .in_dat(in_dat),
    .out_vld(out_vld1), .out_rdy(out_rdy), .out_dat(out_dat1), .sat_cnt(sat1)
  );

  sample_widen #(.WI(WI), .WO(WO), .SYM(0)) dut0 (
    .clk(clk), .rstn(rstn), .in_vld(in_vld), .in_rdy(in_rdy0), .in_dat(in_dat),
    .out_vld(out_vld0), .out_rdy(out_rdy), .out_dat(out_dat0), .sat_cnt(sat0)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [WI-WO-1:0] frac_m();
    logic [WI-WO-1:0] f;
    f = '0;
`ifdef SAMPLE_WIDEN_DITHER_EN
    for (int i = 0; i < WI - WO - 1; i++) f[i] = (i < 16) ? m_lfsr[i] : 1'b0;
`endif
    return f;
  endfunction

  function automatic logic [WO-1:0] code_m(input logic [WO-1:0] d, input bit sym);
    return (sym && d == 10'h200) ? 10'h201 : d;
  endfunction

  // Round-half-away WI->WO stage, as used by the filter output.
  function automatic logic [WO-1:0] roundback(input logic [WI-1:0] x);
    logic signed [31:0] v;
    logic signed [31:0] q;
    v = {x[WI-1], x};
    if (v >= 0) q = (v + 32'sd1048576) >>> 21;
    else        q = -((-v + 32'sd1048576) >>> 21);
    return q[WO-1:0];
  endfunction

  // Expected values use the hand-computed integer part; the fraction comes
  // from the bench's own LFSR model (zero without dither).
  task automatic push(input logic [WO-1:0] d, input logic [WI-1:0] e1, input logic [WI-1:0] e0);
    logic [WI-1:0] f;
    f = {{WO{1'b0}}, frac_m()};
    q1.push_back(e1 | f);
    q0.push_back(e0 | f);
    c1.push_back(code_m(d, 1'b1));
    c0.push_back(code_m(d, 1'b0));
`ifdef SAMPLE_WIDEN_DITHER_EN
    m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
`endif
  endtask

  task automatic send_exp(input logic [WO-1:0] d, input logic [WI-1:0] e1, input logic [WI-1:0] e0);
    bit done;
    done   = 1'b0;
    in_vld = 1'b1;
    in_dat = d;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (in_rdy1) begin
        push(d, e1, e0);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_vld = 1'b0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input logic [WO-1:0] d);
    send_exp(d, {code_m(d, 1'b1), {(WI-WO){1'b0}}}, {code_m(d, 1'b0), {(WI-WO){1'b0}}});
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q1.size() != 0 || q0.size() != 0) && k < 200) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("drain_q1", q1.size(), 0);
    chk("drain_q0", q0.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (out_vld1 && out_rdy) begin
        if (q1.size() == 0) chk("extra_out1", 32'd1, 32'd0);
        else begin
          chk("out_dat1", out_dat1, q1.pop_front());
          chk("roundtrip1", roundback(out_dat1), c1.pop_front());
        end
      end
      if (out_vld0 && out_rdy) begin
        if (q0.size() == 0) chk("extra_out0", 32'd1, 32'd0);
        else begin
          chk("out_dat0", out_dat0, q0.pop_front());
          chk("roundtrip0", roundback(out_dat0), c0.pop_front());
        end
      end
    end
  end

  initial begin
    logic [WO-1:0] a, b, cc;
    a  = 10'h0AA;
    b  = 10'h155;
    cc = 10'h2C3;

    // Reset with input offered
    rstn    = 1'b0;
    in_vld  = 1'b1;
    in_dat  = 10'h155;
    out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_vld", out_vld1, 0);
    chk("rst_out_dat", out_dat1, 0);
    chk("rst_sat", sat1, 0);
    chk("rst_in_rdy", in_rdy1, 1);
    chk("rst_out_vld0", out_vld0, 0);
    rstn   = 1'b1;
    in_vld = 1'b0;
    @(posedge clk);
    #1;

    // First-sample latency
    chk("pre_out_vld", out_vld1, 0);
    send_exp(10'h001, 31'h0020_0000, 31'h0020_0000);
    chk("lat_out_vld", out_vld1, 1);
    chk("lat_code", out_dat1[WI-1:WI-WO], 10'h001);

    // Value table
    send_exp(10'h3FF, 31'h7FE0_0000, 31'h7FE0_0000);
    send_exp(10'h1FF, 31'h3FE0_0000, 31'h3FE0_0000);
    send_exp(10'h000, 31'h0000_0000, 31'h0000_0000);

    // Clamp
    send_exp(10'h200, 31'h4020_0000, 31'h4000_0000);
    repeat (2) @(posedge clk);
    #1;
    chk("sat1_clamp", sat1, 1);
    chk("sat0_clamp", sat0, 0);
    drain();

    // Backpressure: A, B fill the buffer, C waits
    out_rdy = 1'b0;
    send(a);
    send(b);
    in_vld = 1'b1;
    in_dat = cc;
    @(negedge clk);
    chk("bp_in_rdy", in_rdy1, 0);
    chk("bp_hold_a", out_dat1[WI-1:WI-WO], a);
    @(negedge clk);
    chk("bp_in_rdy2", in_rdy1, 0);
    chk("bp_hold_a2", out_dat1[WI-1:WI-WO], a);
    @(posedge clk);
    #1;
    out_rdy = 1'b1;
    fork
      send(cc);
      begin
        @(negedge clk);
        chk("seq_a", {out_vld1, out_dat1[WI-1:WI-WO]}, {1'b1, a});
        @(negedge clk);
        chk("seq_b", {out_vld1, out_dat1[WI-1:WI-WO]}, {1'b1, b});
        @(negedge clk);
        chk("seq_c", {out_vld1, out_dat1[WI-1:WI-WO]}, {1'b1, cc});
      end
    join
    drain();

    // All codes through the round-trip, with intermittent backpressure
    for (int i = 0; i < 1024; i++) begin
      out_rdy = (i % 4 != 3);
      send(WO'(i));
    end
    out_rdy = 1'b1;
    drain();
    chk("sat1_all", sat1, 2);
    chk("sat0_all", sat0, 0);

    // Reset while full
    out_rdy = 1'b0;
    send(10'h011);
    send(10'h022);
    @(negedge clk);
    chk("full_in_rdy", in_rdy1, 0);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("mid_out_vld", out_vld1, 0);
    chk("mid_out_vld0", out_vld0, 0);
    chk("mid_in_rdy", in_rdy1, 1);
    chk("mid_sat", sat1, 0);
    q1.delete();
    q0.delete();
    c1.delete();
    c0.delete();
    m_lfsr = 16'hACE1;
    @(posedge clk);
    #1;
    rstn    = 1'b1;
    out_rdy = 1'b1;
    send(10'h033);
    chk("post_rst_vld", out_vld1, 1);
    send(10'h200);
    drain();
    chk("post_rst_sat", sat1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
